// File: rtl/vram_pkg.sv
// Shared types and default widths for the VRAM arbiter and its helpers.
package vram_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned STALL_W_DEF = 16;

  // CPU-side access lifecycle: waiting, issued read returning, completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    RDATA = 2'd2,
    ACK   = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a clear that wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q, value_d;

  // Next count: clear first, otherwise step unless already all-ones.
  always_comb begin
    // NOTE: assigning a default before any branch keeps this block purely
    // combinational; a path that left value_d unassigned would infer a latch.
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != '1)) begin
      value_d = value_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, regardless of block evaluation order.
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches always win, CPU accesses are held
// in a one-deep pending register and issued into free RAM cycles.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned STALL_W = STALL_W_DEF
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic               vid_rd,
  input  logic [ADDR_W-1:0]  vid_addr,
  output logic [DATA_W-1:0]  vid_data,
  input  logic               cpu_start,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_busy,
  output logic               cpu_ack,
  output logic [DATA_W-1:0]  cpu_rdata,
  input  logic               stall_clr,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               ram_en,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata
);

  state_e              state_q, state_d;
  logic                pend_we_q, pend_we_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0]   pend_wdata_q, pend_wdata_d;
  logic                cpu_busy_q, cpu_busy_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                vid_q, vid_d;
  logic [DATA_W-1:0]   vid_data_q, vid_data_d;

  logic cpu_issue;
  logic stall_inc;

  // The CPU gets the port only when pending and video is not fetching; a reset
  // cycle never issues, so an abandoned access cannot touch the RAM.
  assign cpu_issue = (state_q == PEND) && !vid_rd && !reset;
  assign stall_inc = (state_q == PEND) && vid_rd;

  // Next-state, pending capture, read capture and video issue-tag tracking.
  always_comb begin
    state_d      = state_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    vid_d        = vid_rd;
    vid_data_d   = vid_q ? ram_rdata : vid_data_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_start) begin
          pend_we_d    = cpu_we;
          pend_addr_d  = cpu_addr;
          pend_wdata_d = cpu_wdata;
          state_d      = PEND;
        end
      end
      PEND: begin
        if (cpu_issue) state_d = pend_we_q ? ACK : RDATA;
      end
      RDATA: begin
        // Port is pipelined: this data belongs to last cycle's CPU read even
        // if video is issuing a new fetch right now.
        cpu_rdata_d = ram_rdata;
        state_d     = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cpu_busy_d = (state_d == PEND) || (state_d == RDATA);
    cpu_ack_d  = (state_d == ACK);
  end

  // Control state and visible outputs, cleared by reset.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q     <= IDLE;
      cpu_busy_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_q       <= 1'b0;
      vid_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cpu_busy_q  <= cpu_busy_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_q       <= vid_d;
      vid_data_q  <= vid_data_d;
    end
  end

  // Pending request payload; only meaningful while state is PEND.
  always_ff @(posedge clk_pixel) begin
    // NOTE: pure datapath registers are left without reset; they are always
    // written by cpu_start before the state machine can consume them.
    pend_we_q    <= pend_we_d;
    pend_addr_q  <= pend_addr_d;
    pend_wdata_q <= pend_wdata_d;
  end

  // Port mux: video first, then an issued CPU access, otherwise idle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = pend_addr_q;
    ram_wdata = pend_wdata_q;
    if (vid_rd) begin
      ram_en   = 1'b1;
      ram_addr = vid_addr;
    end else if (cpu_issue) begin
      ram_en = 1'b1;
      ram_we = pend_we_q;
    end
  end

  sat_counter #(
    .WIDTH (STALL_W)
  ) u_stall_cnt (
    .clk   (clk_pixel),
    .reset (reset),
    .inc   (stall_inc),
    .clr   (stall_clr),
    .value (stall_cnt)
  );

  assign vid_data  = vid_data_q;
  assign cpu_busy  = cpu_busy_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a transaction-level model predicts
// acks, read data, video data, stall count and RAM port use.
module tb_vram_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int STALL_MAX = (1 << SW) - 1;

  logic          clk_pixel = 1'b0;
  logic          reset;
  logic          vid_rd;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          cpu_start;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_busy;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          stall_clr;
  logic [SW-1:0] stall_cnt;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always #5 clk_pixel = ~clk_pixel;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STALL_W(SW)) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .vid_rd    (vid_rd),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .cpu_start (cpu_start),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_busy  (cpu_busy),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .stall_clr (stall_clr),
    .stall_cnt (stall_cnt),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Initial RAM image; the constant makes address 0x0100 hold 0x5A.
  function automatic logic [7:0] init_byte(input int a);
    logic [15:0] aa;
    aa = 16'(a);
    return aa[7:0] ^ aa[15:8] ^ 8'h5B;
  endfunction

  // Environment RAM: one-cycle read latency, garbage when not reading.
  logic [7:0] ram [0:65535];
  bit         ram_ready = 1'b0;
  always @(posedge clk_pixel) begin
    if (!ram_ready) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
      ram_ready <= 1'b1;
    end else if (ram_en && ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
    if (ram_en && !ram_we) ram_rdata <= ram[ram_addr];
    else                   ram_rdata <= 8'($urandom);
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    int         due;
    bit         we;
    logic [7:0] data;
  } exp_t;

  exp_t       cpu_sq[$];
  exp_t       vid_sq[$];
  logic [7:0] ref_mem [0:65535];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  bit          has_req, issued;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  int          ack_cyc;
  int          stall_m;

  bit          e_busy, e_en, e_we;
  logic [15:0] e_addr;
  logic [7:0]  e_wdata;
  int          e_stall;
  logic [7:0]  vid_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic purge_future();
    exp_t keep[$];
    keep = {};
    foreach (cpu_sq[i]) if (cpu_sq[i].due <= cyc) keep.push_back(cpu_sq[i]);
    cpu_sq = keep;
    keep = {};
    foreach (vid_sq[i]) if (vid_sq[i].due <= cyc) keep.push_back(vid_sq[i]);
    vid_sq = keep;
  endtask

  // Drive one cycle of inputs, record what the outputs must be in this
  // cycle, then advance the transaction model by the cycle's events.
  task automatic step(input bit rst, input bit vrd, input logic [15:0] va,
                      input bit st, input bit we, input logic [15:0] a,
                      input logic [7:0] wd, input bit clr);
    bit issue, stalled;
    reset = rst; vid_rd = vrd; vid_addr = va;
    cpu_start = st; cpu_we = we; cpu_addr = a; cpu_wdata = wd; stall_clr = clr;

    issue   = has_req && !issued && !vrd && !rst;
    stalled = has_req && !issued && vrd;

    e_busy  = has_req && (!issued || cyc < ack_cyc);
    e_stall = stall_m;
    e_en    = vrd || issue;
    e_we    = issue && req_we;
    e_addr  = vrd ? va : req_addr;
    e_wdata = req_wdata;

    // Video read result is registered once more after the RAM returns it.
    if (vrd) vid_sq.push_back('{cyc + 2, 1'b0, ref_mem[va]});
    if (issue) begin
      issued = 1'b1;
      if (req_we) begin
        ref_mem[req_addr] = req_wdata;
        ack_cyc = cyc + 1;
        cpu_sq.push_back('{cyc + 1, 1'b1, 8'h00});
      end else begin
        ack_cyc = cyc + 2;
        cpu_sq.push_back('{cyc + 2, 1'b0, ref_mem[req_addr]});
      end
    end
    if (clr) stall_m = 0;
    else if (stalled && stall_m < STALL_MAX) stall_m++;

    if (has_req && issued && cyc == ack_cyc) begin
      has_req = 1'b0;
    end else if (!has_req && st) begin
      has_req = 1'b1; issued = 1'b0;
      req_we = we; req_addr = a; req_wdata = wd;
    end

    if (rst) begin
      has_req = 1'b0; issued = 1'b0; stall_m = 0;
      purge_future();
      vid_sq.push_back('{cyc + 1, 1'b0, 8'h00});
    end

    @(posedge clk_pixel);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 0, 16'h0, 8'h0, 0);
  endtask

  task automatic vid(input logic [15:0] va);
    step(0, 1, va, 0, 0, 16'h0, 8'h0, 0);
  endtask

  task automatic cpu(input bit we, input logic [15:0] a, input logic [7:0] wd);
    step(0, 0, 16'h0, 1, we, a, wd, 0);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the scoreboard.
  bit exp_ack;
  always @(negedge clk_pixel) begin
    if (chk_en) begin
      exp_ack = (cpu_sq.size() > 0) && (cpu_sq[0].due == cyc);
      check("cpu_ack", 32'(cpu_ack), 32'(exp_ack));
      if (exp_ack) begin
        if (!cpu_sq[0].we) check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_sq[0].data));
        void'(cpu_sq.pop_front());
      end
      if (vid_sq.size() > 0 && vid_sq[0].due == cyc) begin
        vid_hold = vid_sq[0].data;
        void'(vid_sq.pop_front());
      end
      check("vid_data", 32'(vid_data), 32'(vid_hold));
      check("cpu_busy", 32'(cpu_busy), 32'(e_busy));
      check("stall_cnt", 32'(stall_cnt), 32'(e_stall));
      check("ram_en", 32'(ram_en), 32'(e_en));
      check("ram_we", 32'(ram_we), 32'(e_we));
      if (e_en) check("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (e_we) check("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra, va;
    bit          rst, vrd, st;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
    has_req = 1'b0; issued = 1'b0; ack_cyc = 0; stall_m = 0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; vid_hold = 8'h00;

    // Reset and reset-state checks.
    step(1, 0, 16'h0, 0, 0, 16'h0, 8'h0, 0);
    chk_en = 1'b1;
    step(1, 0, 16'h0, 0, 0, 16'h0, 8'h0, 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    check("rst_vid_data", 32'(vid_data), 32'h0);
    check("rst_stall", 32'(stall_cnt), 32'h0);

    // Video fetch of a preloaded byte, then held through idle cycles.
    vid(16'h0100);
    idle(10);
    check("t1_vid_hold", 32'(vid_data), 32'h5A);

    // Uncontended CPU write, then read back over the video port.
    cpu(1, 16'h2000, 8'hC3);
    idle(4);
    vid(16'h2000);
    idle(2);
    check("t2_readback", 32'(vid_data), 32'hC3);

    // CPU read stalled by five video cycles.
    cpu(0, 16'h2000, 8'h00);
    for (int k = 0; k < 5; k++) vid(16'h0010 + 16'(k));
    idle(1);
    check("t3_stall5", 32'(stall_cnt), 32'd5);
    idle(3);
    check("t3_rdata", 32'(cpu_rdata), 32'hC3);

    // Video fetch lands in the RDATA cycle: no data cross-over.
    cpu(0, 16'h0100, 8'h00);
    idle(1);
    vid(16'h2000);
    idle(2);
    check("t4_cpu_rdata", 32'(cpu_rdata), 32'h5A);
    check("t4_vid_data", 32'(vid_data), 32'hC3);

    // Starts while busy and in the ACK cycle are ignored.
    cpu(1, 16'h3000, 8'hAA);
    cpu(1, 16'h3001, 8'hBB);
    cpu(1, 16'h3002, 8'hCC);
    idle(2);
    vid(16'h3001);
    idle(2);
    check("t5_ignored", 32'(vid_data), 32'(init_byte(16'h3001)));

    // Reset while pending: no ack, busy drops, write abandoned.
    cpu(1, 16'h4000, 8'h11);
    vid(16'h0001);
    step(1, 0, 16'h0, 0, 0, 16'h0, 8'h0, 0);
    idle(3);
    check("t6_busy", 32'(cpu_busy), 32'h0);
    vid(16'h4000);
    idle(2);
    check("t6_abandoned", 32'(vid_data), 32'(init_byte(16'h4000)));

    // Clear wins over a simultaneous stall increment.
    cpu(0, 16'h0010, 8'h00);
    vid(16'h0002);
    step(0, 1, 16'h0003, 0, 0, 16'h0, 8'h0, 1);
    idle(3);
    check("t7_clr", 32'(stall_cnt), 32'h0);

    // Long starvation saturates the stall counter.
    cpu(0, 16'h0011, 8'h00);
    for (int k = 0; k < 20; k++) vid(16'(k));
    idle(4);
    check("t8_sat", 32'(stall_cnt), 32'(STALL_MAX));

    // Randomized traffic on a small address window to force collisions.
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      vrd = !rst && ($urandom_range(0, 2) == 0);
      st  = !rst && ($urandom_range(0, 3) == 0);
      va  = 16'($urandom_range(0, 15));
      ra  = 16'($urandom_range(0, 15));
      step(rst, vrd, va, st, 1'($urandom), ra, 8'($urandom),
           ($urandom_range(0, 49) == 0));
    end

    idle(6);
    check("sb_cpu_drained", 32'(cpu_sq.size()), 32'h0);
    check("sb_vid_drained", 32'(vid_sq.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
